// File: rtl/cyber_cobra_hs.sv
// rtl/cyber_cobra_hs.sv - multi-cycle CYBERcobra core with handshaked fetch, stream input and buffered output
module cyber_cobra_hs #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 10,
    parameter int NUM_REGS = 32,
    parameter int SW_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [SW_W-1:0]   sw_i,
    output logic              imem_req_o,
    output logic [PC_W-1:0]   imem_addr_o,
    input  logic              imem_valid_i,
    input  logic [31:0]       imem_rdata_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   pc_o
);
    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic {FETCH, EXEC} state_t;

    state_t            state, state_next;
    logic [PC_W-1:0]   pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] rf [1:NUM_REGS-1];

    logic              j, b;
    logic [1:0]        ws;
    logic [4:0]        alu_op, ra1, ra2, wa;
    logic [DATA_W-1:0] rd1, rd2, alu_res, wdata;
    logic              alu_flag;
    logic [SH_W-1:0]   shamt;
    logic              in_stall, out_stall, stall, exec_done, rf_we, is_out;
    logic [33:0]       offs_x4;
    logic [PC_W-1:0]   pc_plus4, pc_target, pc_next;

    assign j      = ir[31];
    assign b      = ir[30];
    assign ws     = ir[29:28];
    assign alu_op = ir[27:23];
    assign ra1    = ir[22:18];
    assign ra2    = ir[17:13];
    assign wa     = ir[4:0];
    assign is_out = j && b;

    // Unimplemented register indices simply never match, so they read 0 and drop writes.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ra1 == 5'(i)) rd1 = rf[i];
            if (ra2 == 5'(i)) rd2 = rf[i];
        end
    end

    assign shamt = rd2[SH_W-1:0];

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        case (alu_op)
            5'b00000: alu_res = rd1 + rd2;
            5'b01000: alu_res = rd1 - rd2;
            5'b00100: alu_res = rd1 ^ rd2;
            5'b00110: alu_res = rd1 | rd2;
            5'b00111: alu_res = rd1 & rd2;
            5'b00001: alu_res = rd1 << shamt;
            5'b00101: alu_res = rd1 >> shamt;
            5'b01101: alu_res = $signed(rd1) >>> shamt;
            5'b00010: alu_res = DATA_W'($signed(rd1) < $signed(rd2));
            5'b00011: alu_res = DATA_W'(rd1 < rd2);
            5'b11000: alu_flag = (rd1 == rd2);
            5'b11001: alu_flag = (rd1 != rd2);
            5'b11100: alu_flag = ($signed(rd1) <  $signed(rd2));
            5'b11101: alu_flag = ($signed(rd1) >= $signed(rd2));
            5'b11110: alu_flag = (rd1 <  rd2);
            5'b11111: alu_flag = (rd1 >= rd2);
            default: ;
        endcase
    end

    always_comb begin
        wdata = '0;
        case (ws)
            2'b00: wdata = DATA_W'($signed(ir[27:5]));
            2'b01: wdata = alu_res;
            2'b10: wdata = DATA_W'($signed(sw_i));
            2'b11: wdata = in_data_i;
            default: ;
        endcase
    end

    assign in_ready_o = (state == EXEC) && (ws == 2'b11) && !j && !b;
    assign in_stall   = in_ready_o && !in_valid_i;
    assign out_stall  = (state == EXEC) && is_out && out_valid_o && !out_ready_i;
    assign stall      = in_stall || out_stall;

    assign offs_x4   = {{24{ir[12]}}, ir[12:5], 2'b00};
    assign pc_plus4  = pc + PC_W'(4);
    assign pc_target = pc + offs_x4[PC_W-1:0];

    always_comb begin
        pc_next = pc_plus4;
        if (j && !b)
            pc_next = pc_target;
        else if (!j && b && alu_flag)
            pc_next = pc_target;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        exec_done  = 1'b0;
        case (state)
            FETCH: if (imem_valid_i) state_next = EXEC;
            EXEC: begin
                if (!stall) begin
                    exec_done  = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    assign rf_we = exec_done && !j && !b && (wa != 5'd0);

    always_ff @(posedge clk_i) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rf_we && (wa == 5'(i))) rf[i] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc          <= '0;
            ir          <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
        end else begin
            if ((state == FETCH) && imem_valid_i) ir <= imem_rdata_i;
            if (exec_done) pc <= pc_next;
            // A completing OUT refills the buffer; otherwise a consumed value retires.
            if (exec_done && is_out) begin
                out_data_o  <= rd1;
                out_valid_o <= 1'b1;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

    assign imem_req_o  = (state == FETCH);
    assign imem_addr_o = pc;
    assign pc_o        = pc;

endmodule

// File: tb/tb_cyber_cobra_hs.sv
// tb/tb_cyber_cobra_hs.sv - self-checking bench for cyber_cobra_hs against an instruction-level model
module tb_cyber_cobra_hs;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        imem_req, imem_valid;
    logic [9:0]  imem_addr, pc;
    logic [31:0] imem_rdata;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;

    always #5 clk = ~clk;

    cyber_cobra_hs dut (
        .clk_i(clk), .rst_i(rst), .sw_i(sw),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_valid_i(imem_valid), .imem_rdata_i(imem_rdata),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
        .pc_o(pc)
    );

    logic [31:0] prog [256];
    logic [31:0] m_reg [32];
    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];
    logic [31:0] in_q [$];
    logic [31:0] pend_ins, in_fixed_val;
    logic [4:0]  ops [16];
    bit          pending, in_fixed;
    int          m_pc, checks, errors, fetch_lat, in_prob, rdy_prob, req_cnt, wraps, last_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Architectural model: one call retires one whole instruction.
    task automatic iss_exec(input logic [31:0] ins);
        logic        jf, bf, flag;
        logic [1:0]  ws;
        logic [4:0]  op, wa;
        logic [31:0] a, bv, res, wd;
        int          sh, off;
        jf = ins[31]; bf = ins[30]; ws = ins[29:28]; op = ins[27:23]; wa = ins[4:0];
        a = m_reg[ins[22:18]]; bv = m_reg[ins[17:13]];
        sh = int'(bv[4:0]); off = int'($signed(ins[12:5]));
        res = 0; flag = 0; wd = 0;
        case (op)
            5'b00000: res = a + bv;
            5'b01000: res = a - bv;
            5'b00100: res = a ^ bv;
            5'b00110: res = a | bv;
            5'b00111: res = a & bv;
            5'b00001: res = a << sh;
            5'b00101: res = a >> sh;
            5'b01101: res = $signed(a) >>> sh;
            5'b00010: res = ($signed(a) < $signed(bv)) ? 1 : 0;
            5'b00011: res = (a < bv) ? 1 : 0;
            5'b11000: flag = (a == bv);
            5'b11001: flag = (a != bv);
            5'b11100: flag = ($signed(a) <  $signed(bv));
            5'b11101: flag = ($signed(a) >= $signed(bv));
            5'b11110: flag = (a <  bv);
            5'b11111: flag = (a >= bv);
            default: ;
        endcase
        if (!jf && !bf) begin
            case (ws)
                2'b00: wd = {{9{ins[27]}}, ins[27:5]};
                2'b01: wd = res;
                2'b10: wd = {{16{sw[15]}}, sw};
                default: begin
                    check("in_transfer_present", 32'(in_q.size() != 0), 32'd1);
                    if (in_q.size() != 0) wd = in_q.pop_front();
                end
            endcase
            if (wa != 0) m_reg[wa] = wd;
        end
        if (jf && bf) begin
            exp_q.push_back(a);
            m_pc += 4;
        end else if (jf || (bf && flag)) m_pc += off * 4;
        else m_pc += 4;
        m_pc = m_pc & 'h3FF;
    endtask

    task automatic cycle();
        bit go;
        if (imem_req) begin
            go = (fetch_lat < 0) ? ($urandom_range(2) == 0) : (req_cnt >= fetch_lat);
            if (go) begin
                if (pending) iss_exec(pend_ins);
                check("fetch_addr", 32'(imem_addr), 32'(m_pc));
                check("pc_o", 32'(pc), 32'(m_pc));
                if (last_addr == 'h3FC && imem_addr == 0) wraps++;
                last_addr  = int'(imem_addr);
                pend_ins   = prog[imem_addr[9:2]];
                pending    = 1;
                imem_valid = 1'b1;
                imem_rdata = pend_ins;
                req_cnt    = 0;
            end else begin
                imem_valid = 1'b0;
                imem_rdata = $urandom;
                req_cnt++;
            end
        end else begin
            req_cnt    = 0;
            imem_valid = (fetch_lat < 0) && ($urandom_range(3) == 0);
            imem_rdata = $urandom;
        end
        in_valid = ($urandom_range(99) < in_prob);
        in_data  = in_fixed ? in_fixed_val : $urandom;
        if (in_valid && in_ready) in_q.push_back(in_data);
        out_ready = ($urandom_range(99) < rdy_prob);
        if (out_valid && out_ready) obs_q.push_back(out_data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic assert_reset();
        rst = 1'b1; imem_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic release_reset();
        rst = 1'b0;
        m_pc = 0; pending = 0; req_cnt = 0; last_addr = -1; wraps = 0;
        exp_q.delete(); obs_q.delete(); in_q.delete();
    endtask

    task automatic compare_outputs(input string tag, input bit exact);
        int n, d;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        d = obs_q.size() - exp_q.size();
        if (exact) check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        else       check({tag, "_count_close"}, 32'(d >= -1 && d <= 1 && n >= 4), 32'd1);
        for (int i = 0; i < n; i++) check($sformatf("%s_out[%0d]", tag, i), obs_q[i], exp_q[i]);
    endtask

    task automatic fill_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'h80000000;
    endtask

    task automatic load_prog_a();
        fill_prog();
        prog[0] = 32'h000000A1; prog[1] = 32'h0FFFFFE2; prog[2] = 32'h10044003;
        prog[3] = 32'hC00C0000; prog[4] = 32'hC0040000; prog[5] = 32'h30000004;
        prog[6] = 32'hC0100000; prog[7] = 32'h00000120; prog[8] = 32'hC0000000;
    endtask

    task automatic random_run(input int len, input int ip, input int rp);
        int idx, kind, cnt, end_addr;
        logic [4:0] op;
        fill_prog();
        idx = 0;
        for (int r = 1; r < 32; r++) prog[idx++] = {4'b0000, 23'($urandom), 5'(r)};
        for (int k = 0; k < len; k++) begin
            kind = $urandom_range(9);
            op = ($urandom_range(7) == 0) ? 5'($urandom) : ops[$urandom_range(15)];
            if (kind <= 5)
                prog[idx++] = {2'b00, 2'($urandom), op, 5'($urandom), 5'($urandom), 8'($urandom), 5'($urandom)};
            else if (kind <= 7)
                prog[idx++] = {2'b11, 30'($urandom)};
            else if (kind == 8)
                prog[idx++] = {2'b01, 2'($urandom), op, 5'($urandom), 5'($urandom),
                               8'($urandom_range(1, 3)), 5'($urandom)};
            else
                prog[idx++] = {2'b10, 17'($urandom), 8'($urandom_range(1, 3)), 5'($urandom)};
        end
        end_addr = idx * 4;
        sw = 16'($urandom);
        fetch_lat = -1; in_prob = ip; rdy_prob = rp; in_fixed = 0;
        assert_reset();
        release_reset();
        cnt = 0;
        while (m_pc < end_addr && cnt < 6000) begin
            cycle();
            cnt++;
        end
        check("rand_reached_end", 32'(m_pc >= end_addr), 32'd1);
        rdy_prob = 100;
        repeat (20) cycle();
        compare_outputs("rand", 1);
        check("rand_in_q_empty", 32'(in_q.size()), 32'd0);
    endtask

    initial begin
        int cnt;
        ops = '{5'b00000, 5'b01000, 5'b00100, 5'b00110, 5'b00111, 5'b00001, 5'b00101, 5'b01101,
                5'b00010, 5'b00011, 5'b11000, 5'b11001, 5'b11100, 5'b11101, 5'b11110, 5'b11111};
        checks = 0; errors = 0;
        for (int i = 0; i < 32; i++) m_reg[i] = 0;
        sw = 16'h8001; in_data = 0; imem_rdata = 0; in_fixed = 0; in_fixed_val = 0;
        fetch_lat = 1; in_prob = 0; rdy_prob = 0;

        // Reset state and the basic load/add sequence with one-cycle fetch latency.
        load_prog_a();
        assert_reset();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        release_reset();
        repeat (9) cycle();
        check("three_instr_9cyc_pc", 32'(pc), 32'h0C);
        check("three_instr_9cyc_req", 32'(imem_req), 32'd1);

        // Two back-to-back OUTs under backpressure.
        repeat (20) cycle();
        check("out_stall_valid", 32'(out_valid), 32'd1);
        check("out_stall_data", out_data, 32'd4);
        check("out_stall_pc", 32'(pc), 32'h10);
        check("out_stall_no_fetch", 32'(imem_req), 32'd0);
        rdy_prob = 100;
        cycle();
        rdy_prob = 0;
        check("out_no_gap_valid", 32'(out_valid), 32'd1);
        check("out_no_gap_data", out_data, 32'd5);

        // Input-stream stall.
        cnt = 0;
        while (!in_ready && cnt < 20) begin cycle(); cnt++; end
        check("in_ready_seen", 32'(in_ready), 32'd1);
        repeat (5) cycle();
        check("in_stall_ready", 32'(in_ready), 32'd1);
        check("in_stall_pc", 32'(pc), 32'h14);
        in_fixed = 1; in_fixed_val = 32'h1234; in_prob = 100;
        cycle();
        in_fixed = 0; in_prob = 0;
        check("in_done_pc", 32'(pc), 32'h18);
        rdy_prob = 100;
        repeat (40) cycle();
        compare_outputs("prog_a", 1);

        // Reset while an OUT is stalled.
        rdy_prob = 0;
        assert_reset();
        release_reset();
        repeat (20) cycle();
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        assert_reset();
        check("rst_stall_pc", 32'(pc), 32'd0);
        check("rst_stall_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall_addr", 32'(imem_addr), 32'd0);
        check("rst_stall_req", 32'(imem_req), 32'd1);
        release_reset();

        // Branch taken/not taken and PC wrap at the top of the address space.
        fill_prog();
        prog[0] = 32'h0FFFFFE2; prog[1] = 32'h80000040; prog[2] = 32'h000000E2;
        prog[3] = 32'hC0080000; prog[4] = 32'h4E081FC0; prog[5] = 32'h80001F40;
        prog[6] = 32'h00000000; prog[255] = 32'h80000020;
        fetch_lat = -1; rdy_prob = 100;
        assert_reset();
        release_reset();
        repeat (300) cycle();
        check("wrap_seen", 32'(wraps > 0), 32'd1);
        compare_outputs("branch", 0);

        // Reset while a fetch is outstanding.
        fetch_lat = 50;
        cnt = 0;
        while (!imem_req && cnt < 20) begin cycle(); cnt++; end
        cycle();
        assert_reset();
        check("rst_fetch_pc", 32'(pc), 32'd0);
        check("rst_fetch_addr", 32'(imem_addr), 32'd0);
        check("rst_fetch_req", 32'(imem_req), 32'd1);
        check("rst_fetch_out_valid", 32'(out_valid), 32'd0);
        release_reset();

        random_run(60, 50, 50);
        random_run(80, 80, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
